// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared state encoding and transfer sizes for the cache/memory arbiter
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - I/D cache arbiter for the single AXI memory port
module cache_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              mem_access,
  output logic              mem_write,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_st_data,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              grant_i,
  output logic              grant_d
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t state;
  arb_state_t state_nx;
  logic [3:0] starve_cnt;
  logic       starve_hit;

  // I is forced to win a tie once D has taken STARVE_LIM grants past it
  assign starve_hit = (starve_cnt == STARVE_LIM);

  // state register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state: D has priority unless the starvation guard has tripped
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          state_nx = starve_hit ? BUSY_I : BUSY_D;
        end else if (d_req) begin
          state_nx = BUSY_D;
        end else if (i_req) begin
          state_nx = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs decoded from state; ready pulses follow mem_ready only while busy
  always_comb begin
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    mem_access = 1'b0;
    case (state)
      BUSY_I: begin
        grant_i    = 1'b1;
        mem_access = 1'b1;
        i_ready    = mem_ready;
      end
      BUSY_D: begin
        grant_d    = 1'b1;
        mem_access = 1'b1;
        d_ready    = mem_ready;
      end
      default: ;
    endcase
  end

  // capture the winner on the grant edge and track consecutive D wins over a waiting I
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mem_write   <= 1'b0;
      mem_size    <= SZ_WORD;
      mem_a       <= '0;
      mem_st_data <= '0;
      starve_cnt  <= '0;
    end else if (state == IDLE) begin
      if (state_nx == BUSY_D) begin
        mem_write   <= d_write;
        mem_size    <= d_size;
        mem_a       <= d_addr;
        mem_st_data <= d_wdata;
        if (!i_req) begin
          starve_cnt <= '0;
        end else if (!starve_hit) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else if (state_nx == BUSY_I) begin
        mem_write   <= 1'b0;
        mem_size    <= SZ_WORD;
        mem_a       <= i_addr;
        mem_st_data <= '0;
        starve_cnt  <= '0;
      end
    end
  end

  assign rd_data = mem_data;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - scoreboard bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
  import cpu_mem_pkg::*;

  logic        aclk;
  logic        aresetn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        d_req;
  logic        d_write;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        mem_access;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_a;
  logic [31:0] mem_st_data;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] rd_data;
  logic        grant_i;
  logic        grant_d;

  int checks = 0;
  int errors = 0;
  bit resp_en = 1'b1;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic        w;
    logic [1:0]  sz;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready),
    .mem_access(mem_access), .mem_write(mem_write), .mem_size(mem_size),
    .mem_a(mem_a), .mem_st_data(mem_st_data), .mem_ready(mem_ready),
    .mem_data(mem_data), .rd_data(rd_data), .grant_i(grant_i), .grant_d(grant_d)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C1D_0000;
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_d(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.is_d = 1'b1; e.addr = a; e.w = w; e.sz = sz; e.wd = wd; e.rd = mem_model(a);
    exp_q.push_back(e);
  endfunction

  function automatic void push_i(input logic [31:0] a);
    exp_t e;
    e.is_d = 1'b0; e.addr = a; e.w = 1'b0; e.sz = SZ_WORD; e.wd = '0; e.rd = mem_model(a);
    exp_q.push_back(e);
  endfunction

  // memory responder: completes each access a fixed number of cycles after it appears
  initial begin
    int lat;
    lat = 0;
    mem_ready = 1'b0;
    mem_data  = '0;
    forever begin
      @(posedge aclk);
      #1;
      if (resp_en) begin
        mem_ready = 1'b0;
        if (mem_access) begin
          if (lat == 3) begin
            mem_ready = 1'b1;
            mem_data  = mem_model(mem_a);
            lat = 0;
          end else begin
            lat++;
          end
        end else begin
          lat = 0;
        end
      end
    end
  end

  // monitor: every ready pulse must match the head of the expected queue
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (aresetn && (i_ready || d_ready)) begin
        if (i_ready && d_ready) begin
          chk("both_ready", 32'(i_ready & d_ready), 32'd0);
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready i_ready=%0b d_ready=%0b expected none", i_ready, d_ready);
        end else begin
          e = exp_q.pop_front();
          chk("ready_side", 32'(d_ready), 32'(e.is_d));
          chk("grant_owner", 32'(e.is_d ? grant_d : grant_i), 32'd1);
          chk("grant_excl", 32'(grant_i & grant_d), 32'd0);
          chk("mem_a", mem_a, e.addr);
          chk("mem_write", 32'(mem_write), 32'(e.w));
          chk("mem_size", 32'(mem_size), 32'(e.sz));
          if (e.w) chk("mem_st_data", mem_st_data, e.wd);
          chk("rd_data", rd_data, e.rd);
        end
      end
    end
  end

  task automatic do_d(input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input bit scramble);
    int n;
    d_write = w; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
      if (scramble && grant_d) d_addr = 32'h0;
    end while (!d_ready && n < 100);
    if (!d_ready) chk("d_timeout", 32'(d_ready), 32'd1);
    @(posedge aclk);
    #1;
    d_req = 1'b0;
  endtask

  task automatic do_i(input logic [31:0] a, input bit chk_lat, input bit chk_starve);
    int n;
    bit seen;
    i_addr = a; i_req = 1'b1;
    n = 0;
    seen = 0;
    if (chk_lat) begin
      @(negedge aclk);
      chk("lat_pre_access", 32'(mem_access), 32'd0);
      @(negedge aclk);
      chk("lat_access", 32'(mem_access), 32'd1);
      chk("lat_write", 32'(mem_write), 32'd0);
      chk("lat_size", 32'(mem_size), 32'(SZ_WORD));
      chk("lat_grant_i", 32'(grant_i), 32'd1);
      chk("lat_grant_d", 32'(grant_d), 32'd0);
    end
    do begin
      @(negedge aclk);
      n++;
      if (chk_starve && grant_i && !seen) begin
        seen = 1;
        chk("starve_clr", 32'(dut.starve_cnt), 32'd0);
      end
    end while (!i_ready && n < 200);
    if (!i_ready) chk("i_timeout", 32'(i_ready), 32'd1);
    @(posedge aclk);
    #1;
    i_req = 1'b0;
  endtask

  initial begin
    int n;
    aresetn = 1'b0;
    i_req = 0; i_addr = '0;
    d_req = 0; d_write = 0; d_size = SZ_WORD; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_access", 32'(mem_access), 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_size", 32'(mem_size), 32'(SZ_WORD));
    chk("rst_addr", mem_a, 32'd0);
    chk("rst_st_data", mem_st_data, 32'd0);
    chk("rst_grants", 32'({grant_i, grant_d}), 32'd0);
    chk("rst_readies", 32'({i_ready, d_ready}), 32'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;

    // I only, with latency checks
    push_i(32'hBFC0_0000);
    do_i(32'hBFC0_0000, 1'b1, 1'b0);
    repeat (2) @(posedge aclk);
    #1;

    // simultaneous: D store wins, then I
    push_d(1'b1, SZ_WORD, 32'h8000_1000, 32'hDEAD_BEEF);
    push_i(32'hBFC0_0200);
    fork
      do_d(1'b1, SZ_WORD, 32'h8000_1000, 32'hDEAD_BEEF, 1'b0);
      do_i(32'hBFC0_0200, 1'b0, 1'b0);
    join
    repeat (2) @(posedge aclk);
    #1;

    // starvation: four D grants, then I, then the last D
    for (int k = 0; k < 4; k++) push_d(1'b0, SZ_WORD, 32'h8000_2000 + 32'(k * 4), 32'h0);
    push_i(32'hBFC0_0100);
    push_d(1'b0, SZ_WORD, 32'h8000_2010, 32'h0);
    fork
      begin
        for (int k = 0; k < 5; k++) do_d(1'b0, SZ_WORD, 32'h8000_2000 + 32'(k * 4), 32'h0, 1'b0);
      end
      do_i(32'hBFC0_0100, 1'b0, 1'b1);
    join
    repeat (2) @(posedge aclk);
    #1;

    // stability: d_addr changes mid-transaction
    push_d(1'b0, SZ_HALF, 32'h8000_3002, 32'h0);
    do_d(1'b0, SZ_HALF, 32'h8000_3002, 32'h0, 1'b1);
    repeat (2) @(posedge aclk);
    #1;

    // stray mem_ready while IDLE
    resp_en = 1'b0;
    mem_ready = 1'b1;
    mem_data = 32'h1234_5678;
    @(negedge aclk);
    chk("stray_i_ready", 32'(i_ready), 32'd0);
    chk("stray_d_ready", 32'(d_ready), 32'd0);
    chk("stray_rd_data", rd_data, 32'h1234_5678);
    @(posedge aclk);
    #1;
    mem_ready = 1'b0;
    @(negedge aclk);
    chk("stray_access", 32'(mem_access), 32'd0);

    // reset during BUSY_I
    i_addr = 32'hBFC0_0300;
    i_req = 1'b1;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!grant_i && n < 20);
    chk("rstmid_grant_seen", 32'(grant_i), 32'd1);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    i_req = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rstmid_state", 32'(dut.state), 32'(IDLE));
    chk("rstmid_access", 32'(mem_access), 32'd0);
    chk("rstmid_grant_i", 32'(grant_i), 32'd0);
    chk("rstmid_i_ready", 32'(i_ready), 32'd0);
    repeat (3) @(posedge aclk);
    #1;
    resp_en = 1'b1;

    // byte store, no alignment
    push_d(1'b1, SZ_BYTE, 32'h8000_0003, 32'h0000_00A5);
    do_d(1'b1, SZ_BYTE, 32'h8000_0003, 32'h0000_00A5, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge aclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Arbitrates between the instruction cache (read-only miss fills) and the data cache (load/store misses, uncached accesses) for the single memory port of the AXI interface block.
- Replaces the ad-hoc combinational select in the CPU top level.
- Registers the winning request and holds the grant until the memory port returns mem_ready.
- Gives data-side priority, with a starvation guard for the instruction side.

Parameters:
- ADDR_W, 32, address width of all requester and memory ports.
- DATA_W, 32, data width of all requester and memory ports.
- STARVE_MAX, 4, consecutive D grants allowed while I is waiting before I is forced to win; legal range 1..15.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous reset, active low
- i_req  in  1  I-cache memory request, held high until i_ready
- i_addr  in  ADDR_W  I-cache request address
- i_ready  out  1  one-cycle pulse: I transaction done, mem_data valid
- d_req  in  1  D-cache memory request, held high until d_ready
- d_write  in  1  1 = store, 0 = load
- d_size  in  2  0 = byte, 1 = half, 2 = word
- d_addr  in  ADDR_W  D-cache request address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle pulse: D transaction done
- mem_access  out  1  request to AXI interface, held until mem_ready
- mem_write  out  1  write enable to AXI interface
- mem_size  out  2  transfer size to AXI interface
- mem_a  out  ADDR_W  address to AXI interface
- mem_st_data  out  DATA_W  store data to AXI interface
- mem_ready  in  1  one-cycle completion pulse from AXI interface
- mem_data  in  DATA_W  read data from AXI interface, valid with mem_ready
- rd_data  out  DATA_W  mem_data passthrough, shared by both requesters
- grant_i  out  1  I owns the port (for stall logic)
- grant_d  out  1  D owns the port (for stall logic)

Behaviour:
- Reset (aresetn low at a clock edge):
  - state IDLE; starve_cnt 0.
  - mem_access, mem_write, grant_i, grant_d, i_ready, d_ready all 0.
  - mem_a, mem_st_data 0; mem_size 2'b10.
  - Reset mid-transaction abandons the transaction silently; the AXI interface shares aresetn.
- FSM states: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE transitions:
  - No request: stay in IDLE.
  - Both requesting: go to BUSY_D, unless starve_cnt == STARVE_MAX, then BUSY_I.
  - Only one requesting: grant it.
- On the grant edge:
  - Capture the winner's address, write flag, size and data into the mem_* registers. I always latches write 0 and size 2'b10.
  - Set mem_access to 1.
  - Latency: req sampled at edge N means mem_access is high from N+1.
- starve_cnt:
  - Increments on each D grant taken while i_req is high; saturates at STARVE_MAX.
  - Clears on every I grant.
  - Clears on any D grant taken while i_req is low.
- BUSY_x:
  - mem_* registers and mem_access stay stable until mem_ready.
  - mem_ready == 1 in BUSY_I makes i_ready 1 in the same cycle (combinational from mem_ready and state); same for BUSY_D and d_ready.
  - Next state is DONE; mem_access drops at that edge.
- DONE: one bubble cycle; mem_access 0; requester deasserts req here. Then go to IDLE.
- Requester dropping req during BUSY_x is ignored: the transaction completes and the ready pulse is still issued.
- mem_ready outside BUSY_x is ignored; no ready pulse is generated.
- rd_data = mem_data at all times.
- grant_i / grant_d are high exactly in BUSY_I / BUSY_D; they are never both high.
- Stall contract for the pipeline:
  - I stall = i_req & ~i_ready.
  - D stall = d_req & ~d_ready.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - The state encoding (IDLE = 0, BUSY_I = 1, BUSY_D = 2, DONE = 3).
  - Size constants SZ_BYTE, SZ_HALF, SZ_WORD.
- Single module, no sub-modules. The request capture register plus FSM fits in one file.

Test Plan:
- I only: i_req = 1, i_addr = 0xBFC00000; mem_ready after 3 cycles with mem_data = 0x3C1D0000 -> mem_access high from cycle 1, mem_write = 0, mem_size = 2; i_ready pulses 1 cycle with rd_data = 0x3C1D0000; d_ready stays 0.
- Simultaneous: i_req and d_req both high at the same edge, d_write = 1, d_addr = 0x80001000, d_wdata = 0xDEADBEEF, d_size = 2 -> BUSY_D first with mem_write = 1 and mem_st_data = 0xDEADBEEF; after d_ready, the I request is served next once d_req falls.
- Starvation: d_req re-asserted immediately each time, i_req held continuously -> exactly 4 D grants, then 1 I grant; starve_cnt returns to 0.
- Stability: change d_addr to 0x0 mid-BUSY_D, and pulse mem_ready while IDLE -> mem_a keeps the captured value; no ready pulse from the stray mem_ready.
- Reset mid-operation: aresetn low for 1 cycle during BUSY_I -> next cycle IDLE, mem_access = 0, grant_i = 0, no i_ready pulse.
- Byte store: d_size = 0, d_addr = 0x80000003 -> mem_size = 0, mem_a = 0x80000003 unchanged (no alignment performed).
